// File: rtl/adv7513_i2c_arb.sv
// Round-robin arbiter sharing one ADV7513 I2C master among NUM_REQ register-access requesters.
// One transaction at a time: grant, issue a one-cycle enable, track master busy, then ack.
module adv7513_i2c_arb #(
    parameter int unsigned NUM_REQ   = 3,
    parameter logic [6:0]  CHIP_ADDR = 7'h72,
    parameter logic [15:0] TIMEOUT   = 16'd65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   rw,
    input  logic [8*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           rdata,
    output logic                 err,
    output logic [1:0]           gnt_id,
    output logic [6:0]           m_chip_addr,
    output logic [7:0]           m_reg_addr,
    output logic [7:0]           m_data_in,
    output logic                 m_write_en,
    output logic                 m_read_en,
    input  logic                 m_busy,
    input  logic [2:0]           m_status,
    input  logic [7:0]           m_data_out
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_START = 3'd2,
        WAIT_END   = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  gnt_id_q, gnt_id_d;
    logic [1:0]  last_q, last_d;
    logic        rw_q, rw_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [3:0]  req_ext;
    logic [2:0]  cand;
    logic        win_found;
    logic [1:0]  win_idx;
    logic        win_rw;
    logic [7:0]  win_addr;
    logic [7:0]  win_wdata;
    logic        timeout_hit;

    // Scan from last_q+1 upward with wrap; padding req to 4 bits keeps indices >= NUM_REQ ungrantable.
    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        win_found            = 1'b0;
        win_idx              = '0;
        cand                 = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_q} + 3'(k);
            if (cand >= 3'(NUM_REQ)) begin
                cand = cand - 3'(NUM_REQ);
            end
            if (!win_found && req_ext[cand[1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[1:0];
            end
        end
    end

    always_comb begin
        win_rw    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == 2'(i)) begin
                win_rw    = rw[i];
                win_addr  = req_addr[8*i +: 8];
                win_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    assign timeout_hit = ((cnt_q + 16'd1) == TIMEOUT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (win_found) state_d = ISSUE;
            ISSUE:      state_d = WAIT_START;
            WAIT_START: begin
                if (timeout_hit) begin
                    state_d = DONE;
                end else if (m_busy) begin
                    state_d = WAIT_END;
                end
            end
            WAIT_END:   if (timeout_hit || !m_busy) state_d = DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        m_write_en = 1'b0;
        m_read_en  = 1'b0;
        ack        = '0;
        case (state_q)
            ISSUE: begin
                m_read_en  = rw_q;
                m_write_en = !rw_q;
            end
            DONE: begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    ack[i] = (gnt_id_q == 2'(i));
                end
            end
            default: ;
        endcase
    end

    // Result registers load on DONE entry so rdata/err are already valid while ack is high.
    always_comb begin
        gnt_id_d = gnt_id_q;
        last_d   = last_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if (state_q == IDLE && win_found) begin
            gnt_id_d = win_idx;
            rw_d     = win_rw;
            addr_d   = win_addr;
            wdata_d  = win_wdata;
        end
        if (state_q == ISSUE) begin
            cnt_d = '0;
        end
        if (state_q == WAIT_START || state_q == WAIT_END) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (state_d == DONE && state_q != DONE) begin
            err_d = timeout_hit || (m_status != 3'b000);
            if (rw_q) begin
                rdata_d = m_data_out;
            end
        end
        if (state_q == DONE) begin
            last_d = gnt_id_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt_id_q <= '0;
            last_q   <= 2'(NUM_REQ - 1);
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            gnt_id_q <= gnt_id_d;
            last_q   <= last_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign m_chip_addr = CHIP_ADDR;
    assign m_reg_addr  = addr_q;
    assign m_data_in   = wdata_q;
    assign gnt_id      = gnt_id_q;
    assign rdata       = rdata_q;
    assign err         = err_q;

endmodule

// File: tb/tb_adv7513_i2c_arb.sv
// Bench for adv7513_i2c_arb: random multi-requester traffic against a round-robin reference model,
// a behavioural I2C master, and directed read/NAK/contention/timeout/reset/drop scenarios.
module tb_adv7513_i2c_arb;
    localparam int NR = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req, rw, ack;
    logic [8*NR-1:0] req_addr, req_wdata;
    logic [7:0]      rdata;
    logic            err;
    logic [1:0]      gnt_id;
    logic [6:0]      m_chip_addr;
    logic [7:0]      m_reg_addr, m_data_in;
    logic            m_write_en, m_read_en, m_busy;
    logic [2:0]      m_status;
    logic [7:0]      m_data_out;

    int vectors = 0;
    int miscompares = 0;

    // master model
    int         cfg_busy;
    logic       cfg_stuck;
    logic [2:0] cfg_status;
    logic [7:0] cfg_data;
    int         busy_left;
    logic       start_pend;

    // event monitor
    int         en_cnt, ack_cnt, ticks_since_en;
    logic       en_rd, en_both, en_busy;
    logic [7:0] en_addr, en_data;
    logic [6:0] en_chip;
    logic [NR-1:0] ack_seen;
    logic [7:0] ack_rdata;
    logic       ack_err;
    logic [1:0] ack_gnt;

    // reference model state
    logic [NR-1:0] pend;
    logic          r_rw[NR];
    logic [7:0]    r_addr[NR];
    logic [7:0]    r_wd[NR];
    int            last;
    logic [7:0]    exp_rdata;

    adv7513_i2c_arb #(.NUM_REQ(NR), .CHIP_ADDR(7'h72), .TIMEOUT(16'd100)) dut (
        .clk(clk), .reset(reset), .req(req), .rw(rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .ack(ack), .rdata(rdata), .err(err), .gnt_id(gnt_id), .m_chip_addr(m_chip_addr),
        .m_reg_addr(m_reg_addr), .m_data_in(m_data_in), .m_write_en(m_write_en), .m_read_en(m_read_en),
        .m_busy(m_busy), .m_status(m_status), .m_data_out(m_data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample DUT after the edge, then advance the master model.
    task automatic tick();
        @(posedge clk);
        #1;
        if (m_read_en || m_write_en) begin
            en_cnt++;
            en_rd   = m_read_en;
            en_both = m_read_en && m_write_en;
            en_addr = m_reg_addr;
            en_data = m_data_in;
            en_chip = m_chip_addr;
            en_busy = m_busy;
            ticks_since_en = 0;
        end else begin
            ticks_since_en++;
        end
        if (ack != '0) begin
            ack_cnt++;
            ack_seen  = ack;
            ack_rdata = rdata;
            ack_err   = err;
            ack_gnt   = gnt_id;
        end
        if (!reset) begin
            m_busy = 1'b0; busy_left = 0; start_pend = 1'b0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                m_busy = 1'b0; m_status = cfg_status; m_data_out = cfg_data;
            end
        end else if (start_pend) begin
            start_pend = 1'b0; m_busy = 1'b1; m_status = 3'b000; busy_left = cfg_busy;
        end
        if (reset && (m_read_en || m_write_en) && !cfg_stuck) start_pend = 1'b1;
    endtask

    task automatic wait_ack(input int bound, output int n);
        int start;
        start = ack_cnt;
        n = 0;
        while (ack_cnt == start && n < bound) begin
            tick();
            n++;
        end
        check("ack_within_bound", 32'(ack_cnt - start), 32'd1);
    endtask

    task automatic wait_en(input int bound);
        int start, n;
        start = en_cnt;
        n = 0;
        while (en_cnt == start && n < bound) begin
            tick();
            n++;
        end
        check("en_within_bound", 32'(en_cnt - start), 32'd1);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            req[i] = pend[i];
            rw[i]  = r_rw[i];
            req_addr[8*i +: 8]  = r_addr[i];
            req_wdata[8*i +: 8] = r_wd[i];
        end
    endtask

    task automatic new_req(input int i, input logic is_rd, input logic [7:0] a, input logic [7:0] d);
        pend[i] = 1'b1; r_rw[i] = is_rd; r_addr[i] = a; r_wd[i] = d;
    endtask

    function automatic int rr_pick(input logic [NR-1:0] p, input int from);
        for (int k = 1; k <= NR; k++) begin
            if (p[(from + k) % NR]) return (from + k) % NR;
        end
        return -1;
    endfunction

    initial begin
        int w, n, en0, ack0;
        int order[4];
        order = '{0, 1, 2, 0};
        reset = 1'b0; req = '0; rw = '0; req_addr = '0; req_wdata = '0;
        m_busy = 1'b0; m_status = 3'b000; m_data_out = 8'h00;
        cfg_busy = 1; cfg_stuck = 1'b0; cfg_status = 3'b000; cfg_data = 8'h00;
        busy_left = 0; start_pend = 1'b0;
        en_cnt = 0; ack_cnt = 0; ticks_since_en = 0;
        en_rd = 0; en_both = 0; en_busy = 0; en_addr = 0; en_data = 0; en_chip = 0;
        ack_seen = '0; ack_rdata = 0; ack_err = 0; ack_gnt = 0;
        pend = '0; last = NR - 1; exp_rdata = 8'h00;
        for (int i = 0; i < NR; i++) begin r_rw[i] = 0; r_addr[i] = 0; r_wd[i] = 0; end

        // reset state
        tick(); tick();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_gnt", 32'(gnt_id), 32'd0);
        check("rst_wen", 32'(m_write_en), 32'd0);
        check("rst_ren", 32'(m_read_en), 32'd0);
        check("rst_chip", 32'(m_chip_addr), 32'h72);
        check("rst_regaddr", 32'(m_reg_addr), 32'd0);
        check("rst_din", 32'(m_data_in), 32'd0);
        reset = 1'b1;

        // random traffic
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    new_req(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            end
            if (pend == '0) new_req($urandom_range(0, NR - 1), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            drive_reqs();
            cfg_busy   = $urandom_range(1, 8);
            cfg_status = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            cfg_data   = 8'($urandom);
            w   = rr_pick(pend, last);
            en0 = en_cnt;
            wait_ack(200, n);
            if (r_rw[w]) exp_rdata = cfg_data;
            check("rand_ack", 32'(ack_seen), 32'(1 << w));
            check("rand_gnt", 32'(ack_gnt), 32'(w));
            check("rand_en_count", 32'(en_cnt - en0), 32'd1);
            check("rand_en_excl", 32'(en_both), 32'd0);
            check("rand_en_rd", 32'(en_rd), 32'(r_rw[w]));
            check("rand_regaddr", 32'(en_addr), 32'(r_addr[w]));
            check("rand_din", 32'(en_data), 32'(r_wd[w]));
            check("rand_busy_overlap", 32'(en_busy), 32'd0);
            check("rand_rdata", 32'(ack_rdata), 32'(exp_rdata));
            check("rand_err", 32'(ack_err), 32'(cfg_status != 3'b000));
            check("rand_latency", 32'(n), 32'(cfg_busy + ((t == 0) ? 3 : 4)));
            last = w;
            pend[w] = 1'b0;
            if ($urandom_range(0, 2) == 0) new_req(w, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end
        pend = '0; drive_reqs(); tick(); tick();

        // single read, requester 1
        new_req(1, 1'b1, 8'h42, 8'h00); drive_reqs();
        cfg_busy = 20; cfg_status = 3'b000; cfg_data = 8'hA5; en0 = en_cnt;
        wait_ack(100, n);
        pend = '0; drive_reqs();
        check("rd_ack", 32'(ack_seen), 32'b010);
        check("rd_en_count", 32'(en_cnt - en0), 32'd1);
        check("rd_is_read", 32'(en_rd), 32'd1);
        check("rd_regaddr", 32'(en_addr), 32'h42);
        check("rd_chip", 32'(en_chip), 32'h72);
        check("rd_rdata", 32'(ack_rdata), 32'hA5);
        check("rd_err", 32'(ack_err), 32'd0);
        tick();
        check("rd_ack_one_cycle", 32'(ack), 32'd0);

        // NAK on a write keeps previous read data
        new_req(0, 1'b0, 8'h10, 8'h5A); drive_reqs();
        cfg_busy = 5; cfg_status = 3'b001; cfg_data = 8'hEE;
        wait_ack(100, n);
        pend = '0; drive_reqs();
        check("nak_ack", 32'(ack_seen), 32'b001);
        check("nak_err", 32'(ack_err), 32'd1);
        check("nak_rdata_hold", 32'(ack_rdata), 32'hA5);
        tick();

        // contention after reset: all three writes held
        reset = 1'b0; tick(); reset = 1'b1;
        for (int i = 0; i < NR; i++) new_req(i, 1'b0, 8'(8'h20 + i), 8'(8'h30 + i));
        drive_reqs();
        cfg_status = 3'b000; cfg_busy = 3;
        for (int j = 0; j < 4; j++) begin
            en0 = en_cnt; ack0 = ack_cnt;
            wait_ack(100, n);
            check("cont_ack", 32'(ack_seen), 32'(1 << order[j]));
            check("cont_one_ack", 32'(ack_cnt - ack0), 32'd1);
            check("cont_one_en", 32'(en_cnt - en0), 32'd1);
            check("cont_write", 32'(en_rd), 32'd0);
            check("cont_regaddr", 32'(en_addr), 32'(8'h20 + order[j]));
            check("cont_busy_overlap", 32'(en_busy), 32'd0);
        end
        pend = '0; drive_reqs(); tick();

        // timeout: master never goes busy
        cfg_stuck = 1'b1; cfg_status = 3'b000;
        new_req(0, 1'b0, 8'h77, 8'h01); drive_reqs();
        wait_en(10);
        wait_ack(300, n);
        pend = '0; drive_reqs();
        check("to_ack", 32'(ack_seen), 32'b001);
        check("to_err", 32'(ack_err), 32'd1);
        check("to_cycles_after_wait_start", 32'(n - 1), 32'd100);
        cfg_stuck = 1'b0;
        tick();

        // reset during WAIT_END
        new_req(2, 1'b1, 8'h55, 8'h66); drive_reqs();
        cfg_busy = 10; cfg_data = 8'h99;
        wait_en(10);
        tick(); tick();
        reset = 1'b0; ack0 = ack_cnt;
        tick();
        check("mid_rst_no_ack", 32'(ack_cnt - ack0), 32'd0);
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_rdata", 32'(rdata), 32'd0);
        check("mid_rst_gnt", 32'(gnt_id), 32'd0);
        check("mid_rst_en", 32'({m_write_en, m_read_en}), 32'd0);
        check("mid_rst_regaddr", 32'(m_reg_addr), 32'd0);
        check("mid_rst_din", 32'(m_data_in), 32'd0);
        check("mid_rst_chip", 32'(m_chip_addr), 32'h72);
        reset = 1'b1;
        new_req(0, 1'b0, 8'h01, 8'h02); drive_reqs();
        cfg_busy = 2;
        wait_ack(100, n);
        pend = '0; drive_reqs();
        check("post_rst_first", 32'(ack_seen), 32'b001);
        tick();

        // dropped request still completes, no re-grant
        new_req(2, 1'b0, 8'h3C, 8'hC3); drive_reqs();
        cfg_busy = 10;
        wait_en(10);
        tick(); tick();
        pend = '0; drive_reqs();
        wait_ack(100, n);
        check("drop_ack", 32'(ack_seen), 32'b100);
        en0 = en_cnt; ack0 = ack_cnt;
        for (int i = 0; i < 20; i++) tick();
        check("drop_no_regrant", 32'(en_cnt - en0), 32'd0);
        check("drop_no_ack", 32'(ack_cnt - ack0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/adv7513_i2c_arb.md
ADV7513_I2C_ARB -- requirements
Module: adv7513_i2c_arb

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- NUM_REQ, 3, number of requesters (2..4)
- CHIP_ADDR, 7'h72, I2C chip address driven to the shared master
- TIMEOUT, 16'd65535, maximum clk cycles in the wait states before abort
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock
- reset, in, 1, synchronous, active-low
- req, in, NUM_REQ, per-requester transaction request, level
- rw, in, NUM_REQ, per-requester 1=read, 0=write
- req_addr, in, 8*NUM_REQ, register address; requester i uses bits [8i+7:8i]
- req_wdata, in, 8*NUM_REQ, write data; same packing as req_addr
- ack, out, NUM_REQ, one-cycle completion pulse to the granted requester
- rdata, out, 8, read data, valid with ack
- err, out, 1, failure flag, valid with ack
- gnt_id, out, 2, index of the current or last granted requester
- m_chip_addr, out, 7, to i2c_master chip_addr
- m_reg_addr, out, 8, to i2c_master reg_addr
- m_data_in, out, 8, to i2c_master data_in
- m_write_en, out, 1, to i2c_master write_en
- m_read_en, out, 1, to i2c_master read_en
- m_busy, in, 1, from i2c_master busy
- m_status, in, 3, from i2c_master status; nonzero means NAK or bus error
- m_data_out, in, 8, from i2c_master data_out

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT_START, WAIT_END and DONE, with an encoding safe against illegal states; any illegal state SHALL return to IDLE.
REQ-004 IDLE SHALL behave as follows:
- if any req bit is set, pick a winner round-robin, starting from index (last_served+1) mod NUM_REQ and scanning upward with wrap;
- latch gnt_id, the winner's rw, its address, and its wdata into internal registers;
- go to ISSUE.
REQ-005 ISSUE SHALL behave as follows:
- drive m_chip_addr=CHIP_ADDR, m_reg_addr and m_data_in from the latched values;
- assert exactly one of m_read_en (rw=1) or m_write_en (rw=0) for exactly one cycle;
- clear the timeout counter;
- go to WAIT_START.
REQ-006 WAIT_START SHALL go to WAIT_END when m_busy=1.
REQ-007 WAIT_END SHALL go to DONE when m_busy=0.
REQ-008 The timeout counter SHALL increment each cycle in WAIT_START and WAIT_END; if it reaches TIMEOUT, the FSM SHALL go to DONE with the timeout flag set.
REQ-009 DONE SHALL behave as follows:
- pulse ack[gnt_id] for one cycle;
- set rdata=m_data_out for a read, and hold the previous rdata for a write;
- set err=1 on timeout or m_status!=0, else err=0;
- set last_served=gnt_id;
- go to IDLE.
REQ-010 m_chip_addr, m_reg_addr and m_data_in SHALL hold stable from ISSUE until the cycle after DONE.
REQ-011 Minimum latency from req sampled in IDLE to ack SHALL be 4 cycles plus the i2c_master busy duration.
REQ-012 Dropping req after the grant SHALL NOT abort the transaction; ack SHALL still pulse.
REQ-013 Requester handshake rules:
- a requester SHALL hold req, rw, addr and wdata stable until its ack;
- req still high in the cycle after ack SHALL be treated as a new request, arbitrated with round-robin priority last.
REQ-014 Arbitration SHALL occur only in IDLE; req changes in other states SHALL be ignored until the return to IDLE.
REQ-015 When simultaneous requests occur, every continuously asserted requester SHALL be served within NUM_REQ transactions, so there is no starvation.
REQ-016 Requester indices >= NUM_REQ SHALL never be granted.

Reset
REQ-017 On reset=0 at a clk edge, the block SHALL enter the following state:
- FSM in IDLE;
- ack=0, err=0, rdata=8'h00, gnt_id=0;
- m_write_en=0, m_read_en=0, m_chip_addr=CHIP_ADDR, m_reg_addr=0, m_data_in=0;
- last_served=NUM_REQ-1, so that requester 0 wins first;
- timeout counter cleared.
REQ-018 Reset asserted mid-transaction SHALL abort the transaction with no ack pulse, since the i2c_master shares the same reset.

Verification
REQ-019 Single read: req[1]=1, rw[1]=1, addr=8'h42; the model busies for 20 cycles and returns 8'hA5 with status 0 -> m_read_en pulses once with m_reg_addr=8'h42, ack[1] pulses once, rdata=8'hA5, err=0.
REQ-020 Contention: req=3'b111 held, all writes -> grant order 0,1,2,0, exactly one ack per transaction, and m_write_en never overlaps m_busy from a prior transaction.
REQ-021 NAK: m_status=3'b001 at busy fall -> ack pulses with err=1, and rdata is unchanged for a write.
REQ-022 Timeout: m_busy stuck at 0 after ISSUE, with TIMEOUT=100 -> ack plus err=1 exactly 100 cycles after WAIT_START entry.
REQ-023 Reset during WAIT_END -> next cycle has all outputs at REQ-017 values, no ack, and req[0] is granted first afterwards.
REQ-024 Dropped request: req[2] deasserted during WAIT_END -> ack[2] still pulses, and no re-grant to 2 occurs without a new req.
